// File: rtl/npi_pkg.sv
// ---------------------------------------------------------------------------
// npi_pkg
// Shared constants and types for the NPI write arbiter.
//   state_t        : arbiter FSM state encoding
//   NPI_BURST_LEN  : words per burst for the 128-byte Size code
//   NPI_SIZE_128B  : NPI Size code driven on every request
//   NPI_WR_BE      : write byte-enable, all lanes on
//   NPI_ALIGN_BITS : low address bits cleared for burst alignment
// ---------------------------------------------------------------------------
package npi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_PUSH  = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int unsigned NPI_BURST_LEN  = 16;
    localparam logic [3:0]  NPI_SIZE_128B  = 4'h4;
    localparam logic [7:0]  NPI_WR_BE      = 8'hFF;
    localparam int unsigned NPI_ALIGN_BITS = 7;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin selector with a last-grant pointer.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   req_i[1:0]     : requests (bit n = requester n)
//   commit_i       : pulse recording commit_idx_i as the last granted
//   commit_idx_i   : requester that just finished its burst
//   grant_valid_o  : at least one request present
//   grant_idx_o    : winning requester index
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       commit_i,
    input  logic       commit_idx_i,
    output logic       grant_valid_o,
    output logic       grant_idx_o
);

    logic last_q;

    // Pointer starts at requester 1 so requester 0 wins the first contest.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else if (commit_i) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            last_q <= commit_idx_i;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the block leaves the output
        // unassigned, which would otherwise infer a latch.
        grant_idx_o = 1'b0;
        unique case (req_i)
            2'b01:   grant_idx_o = 1'b0;
            2'b10:   grant_idx_o = 1'b1;
            2'b11:   grant_idx_o = ~last_q;
            default: grant_idx_o = 1'b0;
        endcase
    end

    assign grant_valid_o = |req_i;

endmodule

// File: rtl/npi_write_arbiter.sv
// ---------------------------------------------------------------------------
// npi_write_arbiter
// Arbitrates two burst writers onto one Xilinx MPMC NPI write port. Each burst
// pushes BURST_LEN words into the NPI write FIFO, then issues the address.
//   dram_clk, rst_n          : sole clock, asynchronous active-low reset
//   req0/1, addr0/1, data0/1 : requester burst request, byte address, FWFT word
//   pop0/1                   : requester word consumed this cycle
//   done0/1                  : one-cycle burst-complete pulse
//   XIL_NPI_*                : NPI write-side address and write-FIFO signals
// ---------------------------------------------------------------------------
module npi_write_arbiter
    import npi_pkg::*;
#(
    parameter int C_PI_ADDR_WIDTH = 32,
    parameter int C_PI_DATA_WIDTH = 64,
    parameter int BURST_LEN       = NPI_BURST_LEN
) (
    input  logic                       dram_clk,
    input  logic                       rst_n,
    input  logic                       req0,
    input  logic                       req1,
    input  logic [C_PI_ADDR_WIDTH-1:0] addr0,
    input  logic [C_PI_ADDR_WIDTH-1:0] addr1,
    input  logic [C_PI_DATA_WIDTH-1:0] data0,
    input  logic [C_PI_DATA_WIDTH-1:0] data1,
    output logic                       pop0,
    output logic                       pop1,
    output logic                       done0,
    output logic                       done1,
    output logic [C_PI_ADDR_WIDTH-1:0] XIL_NPI_Addr,
    output logic                       XIL_NPI_AddrReq,
    input  logic                       XIL_NPI_AddrAck,
    output logic                       XIL_NPI_RNW,
    output logic [3:0]                 XIL_NPI_Size,
    output logic                       XIL_NPI_RdModWr,
    output logic [C_PI_DATA_WIDTH-1:0] XIL_NPI_WrFIFO_Data,
    output logic [7:0]                 XIL_NPI_WrFIFO_BE,
    output logic                       XIL_NPI_WrFIFO_Push,
    output logic                       XIL_NPI_WrFIFO_Flush,
    input  logic                       XIL_NPI_WrFIFO_AlmostFull,
    input  logic                       XIL_NPI_InitDone
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_LEN - 1);
    localparam logic [C_PI_ADDR_WIDTH-1:0] ALIGN_MASK =
        {{(C_PI_ADDR_WIDTH - NPI_ALIGN_BITS){1'b1}}, {NPI_ALIGN_BITS{1'b0}}};

    state_t                     state_q;
    logic                       winner_q;
    logic [C_PI_ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]           cnt_q;
    logic                       addr_req_q;
    logic [1:0]                 done_q;

    logic push;
    logic rr_valid;
    logic rr_idx;

    rr_arb2 u_rr_arb2 (
        .clk_i        (dram_clk),
        .rst_ni       (rst_n),
        .req_i        ({req1, req0}),
        .commit_i     (state_q == ST_DONE),
        .commit_idx_i (winner_q),
        .grant_valid_o(rr_valid),
        .grant_idx_o  (rr_idx)
    );

    // A word moves only when the NPI FIFO has room; AlmostFull simply holds
    // the counter, so stalls neither drop nor repeat words.
    assign push = (state_q == ST_PUSH) && !XIL_NPI_WrFIFO_AlmostFull;

    always_ff @(posedge dram_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            winner_q   <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            addr_req_q <= 1'b0;
            done_q     <= 2'b00;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (XIL_NPI_InitDone && rr_valid) begin
                        winner_q <= rr_idx;
                        state_q  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    addr_q  <= (winner_q ? addr1 : addr0) & ALIGN_MASK;
                    cnt_q   <= '0;
                    state_q <= ST_PUSH;
                end
                ST_PUSH: begin
                    if (push) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_WORD) begin
                            addr_req_q <= 1'b1;
                            state_q    <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (XIL_NPI_AddrAck) begin
                        addr_req_q       <= 1'b0;
                        done_q[winner_q] <= 1'b1;
                        state_q          <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 2'b00;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pop0  = push && !winner_q;
    assign pop1  = push &&  winner_q;
    assign done0 = done_q[0];
    assign done1 = done_q[1];

    assign XIL_NPI_Addr         = addr_q;
    assign XIL_NPI_AddrReq      = addr_req_q;
    assign XIL_NPI_RNW          = 1'b0;
    assign XIL_NPI_Size         = NPI_SIZE_128B;
    assign XIL_NPI_RdModWr      = 1'b0;
    assign XIL_NPI_WrFIFO_Data  = (state_q == ST_PUSH) ? (winner_q ? data1 : data0) : '0;
    assign XIL_NPI_WrFIFO_BE    = NPI_WR_BE;
    assign XIL_NPI_WrFIFO_Push  = push;
    assign XIL_NPI_WrFIFO_Flush = 1'b0;

endmodule

// File: tb/tb_npi_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_npi_write_arbiter
// Drives two FWFT requesters and a reactive NPI port model, records what the
// arbiter pushes, and compares against expectations built from the
// round-robin rule and an incrementing word pattern per requester.
// ---------------------------------------------------------------------------
module tb_npi_write_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BL = 16;

    logic          dram_clk = 1'b0;
    logic          rst_n;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] data0, data1;
    logic          pop0, pop1, done0, done1;
    logic [AW-1:0] npi_addr;
    logic          npi_addr_req, npi_addr_ack, npi_rnw, npi_rmw;
    logic [3:0]    npi_size;
    logic [DW-1:0] npi_wdata;
    logic [7:0]    npi_be;
    logic          npi_push, npi_flush, npi_af, npi_init_done;

    always #5 dram_clk = ~dram_clk;

    npi_write_arbiter #(
        .C_PI_ADDR_WIDTH(AW),
        .C_PI_DATA_WIDTH(DW),
        .BURST_LEN      (BL)
    ) dut (
        .dram_clk                 (dram_clk),
        .rst_n                    (rst_n),
        .req0                     (req0),
        .req1                     (req1),
        .addr0                    (addr0),
        .addr1                    (addr1),
        .data0                    (data0),
        .data1                    (data1),
        .pop0                     (pop0),
        .pop1                     (pop1),
        .done0                    (done0),
        .done1                    (done1),
        .XIL_NPI_Addr             (npi_addr),
        .XIL_NPI_AddrReq          (npi_addr_req),
        .XIL_NPI_AddrAck          (npi_addr_ack),
        .XIL_NPI_RNW              (npi_rnw),
        .XIL_NPI_Size             (npi_size),
        .XIL_NPI_RdModWr          (npi_rmw),
        .XIL_NPI_WrFIFO_Data      (npi_wdata),
        .XIL_NPI_WrFIFO_BE        (npi_be),
        .XIL_NPI_WrFIFO_Push      (npi_push),
        .XIL_NPI_WrFIFO_Flush     (npi_flush),
        .XIL_NPI_WrFIFO_AlmostFull(npi_af),
        .XIL_NPI_InitDone         (npi_init_done)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Requester and arbitration model state.
    bit want[2];
    bit keep[2];
    int wi[2];
    int bursts[2];
    int model_last;

    // Observations gathered by run_burst.
    logic [DW-1:0] obs_words[$];
    logic [AW-1:0] obs_addr[$];
    int            obs_done_order[$];
    int            obs_push, obs_pop[2], obs_done[2], obs_viol, obs_af_push, obs_first_push;
    bit            obs_timeout;

    function automatic logic [DW-1:0] pattern(input int rid, input int tag, input int word);
        return {16'hA000 + 16'(rid), 16'(tag), 32'(word)};
    endfunction

    // Round-robin rule: contested -> the one not granted last; else the sole requester.
    function automatic int rr_pick(input bit r0, input bit r1, input int last);
        if (r0 && r1) return 1 - last;
        return r1 ? 1 : 0;
    endfunction

    function automatic logic [AW-1:0] aligned(input logic [AW-1:0] a);
        return {a[AW-1:7], 7'b0};
    endfunction

    task automatic apply_reset();
        want = '{0, 0};
        req0 = 0; req1 = 0; npi_addr_ack = 0; npi_af = 0;
        rst_n = 0;
        repeat (2) @(posedge dram_clk);
        @(negedge dram_clk);
        rst_n = 1;
        @(posedge dram_clk); #1;
        model_last = 1;
        wi = '{0, 0};
    endtask

    // Runs cycles (entered and left just after a rising edge) acting as both
    // requesters and the NPI port, until n_dones bursts finish plus a tail,
    // stop_pushes words are seen, or the cycle budget expires.
    task automatic run_burst(input int n_dones, input int stop_pushes, input bit af_rand,
                             input int af_at, input int af_len, input int ack_delay,
                             input int ack_hold, input int drop_at, input int tail,
                             input int budget);
        int cyc = 0, dones = 0, tail_left = -1, areq_seen = 0, ack_left = 0, af_left = 0;
        bit ack_started = 0, af_used = 0, p0, p1;
        obs_words.delete(); obs_addr.delete(); obs_done_order.delete();
        obs_push = 0; obs_pop = '{0, 0}; obs_done = '{0, 0};
        obs_viol = 0; obs_af_push = 0; obs_first_push = -1; obs_timeout = 0;
        forever begin
            data0 = pattern(0, bursts[0], wi[0]);
            data1 = pattern(1, bursts[1], wi[1]);
            req0 = want[0];
            req1 = want[1];
            if (af_rand) begin
                npi_af = ($urandom_range(0, 2) == 0);
            end else begin
                if (!af_used && af_len > 0 && obs_push == af_at) begin
                    af_left = af_len;
                    af_used = 1;
                end
                npi_af = (af_left > 0);
            end
            if (npi_addr_req === 1'b1) areq_seen++;
            if (!ack_started && npi_addr_req === 1'b1 && areq_seen >= ack_delay) begin
                ack_started = 1;
                ack_left    = ack_hold;
            end
            npi_addr_ack = (ack_left > 0);

            @(negedge dram_clk);
            p0 = (pop0 === 1'b1);
            p1 = (pop1 === 1'b1);
            if (npi_push === 1'b1) begin
                obs_words.push_back(npi_wdata);
                if (obs_first_push < 0) obs_first_push = cyc;
                obs_push++;
                if (npi_af) obs_af_push++;
                if (drop_at >= 0 && obs_push == drop_at) begin
                    want = '{0, 0};
                    npi_init_done = 0;
                end
            end
            if ((npi_push === 1'b1) != (p0 || p1) || (p0 && p1)) obs_viol++;
            if (npi_addr_req === 1'b1) obs_addr.push_back(npi_addr);
            obs_pop[0] += int'(p0);
            obs_pop[1] += int'(p1);
            for (int r = 0; r < 2; r++) begin
                if ((r == 0 ? done0 : done1) === 1'b1) begin
                    obs_done[r]++;
                    obs_done_order.push_back(r);
                    bursts[r]++;
                    wi[r]   = 0;
                    want[r] = keep[r];
                    dones++;
                    areq_seen   = 0;
                    ack_started = 0;
                end
            end
            if (dones >= n_dones && tail_left < 0) tail_left = tail;
            if (stop_pushes > 0 && obs_push >= stop_pushes) return;

            @(posedge dram_clk); #1;
            if (p0) wi[0]++;
            if (p1) wi[1]++;
            if (af_left > 0) af_left--;
            if (ack_left > 0) ack_left--;
            cyc++;
            if (tail_left == 0) return;
            if (tail_left > 0) tail_left--;
            if (cyc >= budget) begin
                obs_timeout = 1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        req0 = 0; req1 = 0; addr0 = '0; addr1 = '0; data0 = '1; data1 = '1;
        npi_addr_ack = 0; npi_af = 0; npi_init_done = 1;
        want = '{0, 0}; keep = '{0, 0}; bursts = '{0, 0}; wi = '{0, 0};
        #3;
        n_assert++;
        if ({pop0, pop1, done0, done1, npi_addr_req, npi_push, npi_addr, npi_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got pop=%b%b done=%b%b areq=%b push=%b addr=%h data=%h required all 0",
                     pop0, pop1, done0, done1, npi_addr_req, npi_push, npi_addr, npi_wdata);
        end
        n_assert++;
        if ({npi_rnw, npi_size, npi_rmw, npi_be, npi_flush} !== {1'b0, 4'h4, 1'b0, 8'hFF, 1'b0}) begin
            n_fail++;
            $display("FAIL tied_outputs: got rnw=%b size=%h rmw=%b be=%h flush=%b required 0/4/0/ff/0",
                     npi_rnw, npi_size, npi_rmw, npi_be, npi_flush);
        end
        apply_reset();
        run_burst(1, 0, 0, 0, 0, 1, 1, -1, 0, 5);
        n_assert++;
        if (obs_push != 0 || obs_addr.size() != 0 || obs_done[0] + obs_done[1] != 0) begin
            n_fail++;
            $display("FAIL idle_quiet: got push=%0d areq=%0d done=%0d required 0/0/0",
                     obs_push, obs_addr.size(), obs_done[0] + obs_done[1]);
        end
    endtask

    task automatic test_single_burst();
        int w, tag;
        logic [DW-1:0] got;
        addr0 = 32'h9000_0044;
        addr1 = $urandom;
        want = '{1, 0}; keep = '{0, 0};
        w   = rr_pick(1, 0, model_last);
        tag = bursts[w];
        run_burst(1, 0, 0, 0, 0, 1, 1, -1, 2, 200);
        model_last = w;
        n_assert++;
        if (obs_timeout || obs_push != BL || obs_pop[0] != BL || obs_pop[1] != 0) begin
            n_fail++;
            $display("FAIL single_counts: got timeout=%0d push=%0d pop0=%0d pop1=%0d required 0/16/16/0",
                     obs_timeout, obs_push, obs_pop[0], obs_pop[1]);
        end
        for (int i = 0; i < BL; i++) begin
            got = (i < obs_words.size()) ? obs_words[i] : '1;
            n_assert++;
            if (got !== pattern(w, tag, i)) begin
                n_fail++;
                $display("FAIL single_word[%0d]: got %h required %h", i, got, pattern(w, tag, i));
            end
        end
        n_assert++;
        if (obs_addr.size() != 1 || obs_addr[0] !== 32'h9000_0000) begin
            n_fail++;
            $display("FAIL single_addr: got %0d req cycles addr=%h required 1 cycle addr=90000000",
                     obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : '1);
        end
        n_assert++;
        if (obs_done[0] != 1 || obs_done[1] != 0 || obs_viol != 0) begin
            n_fail++;
            $display("FAIL single_done: got done0=%0d done1=%0d viol=%0d required 1/0/0",
                     obs_done[0], obs_done[1], obs_viol);
        end
    endtask

    task automatic test_round_robin();
        int w, last, tag[2], exp_w[4], exp_tag[4];
        logic [DW-1:0] got;
        apply_reset();
        addr0 = $urandom; addr1 = $urandom;
        last = model_last;
        tag  = bursts;
        for (int k = 0; k < 4; k++) begin
            w          = rr_pick(1, 1, last);
            exp_w[k]   = w;
            exp_tag[k] = tag[w];
            tag[w]++;
            last = w;
        end
        want = '{1, 1}; keep = '{1, 1};
        run_burst(4, 0, 0, 0, 0, 1, 1, -1, 0, 400);
        model_last = last;
        want = '{0, 0}; req0 = 0; req1 = 0;
        n_assert++;
        if (obs_timeout || obs_push != 4 * BL || obs_viol != 0) begin
            n_fail++;
            $display("FAIL rr_counts: got timeout=%0d push=%0d viol=%0d required 0/64/0",
                     obs_timeout, obs_push, obs_viol);
        end
        for (int k = 0; k < 4; k++) begin
            n_assert++;
            if (k >= obs_done_order.size() || obs_done_order[k] != exp_w[k]) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %0d required %0d", k,
                         (k < obs_done_order.size()) ? obs_done_order[k] : -1, exp_w[k]);
            end
            for (int i = 0; i < BL; i++) begin
                got = (k * BL + i < obs_words.size()) ? obs_words[k * BL + i] : '1;
                n_assert++;
                if (got !== pattern(exp_w[k], exp_tag[k], i)) begin
                    n_fail++;
                    $display("FAIL rr_word[%0d][%0d]: got %h required %h", k, i, got,
                             pattern(exp_w[k], exp_tag[k], i));
                end
            end
        end
    endtask

    task automatic test_almost_full();
        int w, tag;
        logic [DW-1:0] got;
        addr0 = $urandom;
        want = '{1, 0}; keep = '{0, 0};
        w   = rr_pick(1, 0, model_last);
        tag = bursts[w];
        run_burst(1, 0, 0, 4, 4, 1, 1, -1, 0, 200);
        model_last = w;
        n_assert++;
        if (obs_timeout || obs_push != BL || obs_pop[w] != BL || obs_af_push != 0) begin
            n_fail++;
            $display("FAIL af_counts: got timeout=%0d push=%0d pop=%0d push_while_af=%0d required 0/16/16/0",
                     obs_timeout, obs_push, obs_pop[w], obs_af_push);
        end
        for (int i = 0; i < BL; i++) begin
            got = (i < obs_words.size()) ? obs_words[i] : '1;
            n_assert++;
            if (got !== pattern(w, tag, i)) begin
                n_fail++;
                $display("FAIL af_word[%0d]: got %h required %h", i, got, pattern(w, tag, i));
            end
        end
    endtask

    task automatic test_addr_ack_delay();
        int w;
        int bad = 0;
        addr1 = $urandom;
        want = '{0, 1}; keep = '{0, 0};
        w = rr_pick(0, 1, model_last);
        run_burst(1, 0, 0, 0, 0, 10, 3, -1, 6, 200);
        model_last = w;
        foreach (obs_addr[i]) if (obs_addr[i] !== aligned(addr1)) bad++;
        n_assert++;
        if (obs_addr.size() != 10 || bad != 0) begin
            n_fail++;
            $display("FAIL ack_delay_areq: got %0d req cycles (%0d wrong addr) required 10 at %h",
                     obs_addr.size(), bad, aligned(addr1));
        end
        n_assert++;
        if (obs_timeout || obs_done[w] != 1 || obs_done[1 - w] != 0 || obs_push != BL) begin
            n_fail++;
            $display("FAIL ack_delay_done: got timeout=%0d done=%0d/%0d push=%0d required 0/1/0/16",
                     obs_timeout, obs_done[w], obs_done[1 - w], obs_push);
        end
    endtask

    task automatic test_init_done();
        int w, tag;
        logic [DW-1:0] got;
        addr1 = $urandom;
        npi_init_done = 0;
        want = '{0, 1}; keep = '{0, 0};
        run_burst(1, 0, 0, 0, 0, 1, 1, -1, 0, 8);
        n_assert++;
        if (!obs_timeout || obs_push != 0 || obs_addr.size() != 0) begin
            n_fail++;
            $display("FAIL init_hold: got finished=%0d push=%0d areq=%0d required no activity",
                     !obs_timeout, obs_push, obs_addr.size());
        end
        npi_init_done = 1;
        w   = rr_pick(0, 1, model_last);
        tag = bursts[w];
        // Request and InitDone both fall after the third push; burst must finish.
        run_burst(1, 0, 0, 0, 0, 1, 1, 3, 0, 200);
        npi_init_done = 1;
        model_last = w;
        n_assert++;
        if (obs_first_push < 0 || obs_first_push > 2) begin
            n_fail++;
            $display("FAIL init_start: got first push at cycle %0d required 0..2", obs_first_push);
        end
        n_assert++;
        if (obs_timeout || obs_push != BL || obs_pop[w] != BL || obs_done[w] != 1) begin
            n_fail++;
            $display("FAIL init_drop_burst: got timeout=%0d push=%0d pop=%0d done=%0d required 0/16/16/1",
                     obs_timeout, obs_push, obs_pop[w], obs_done[w]);
        end
        for (int i = 0; i < BL; i++) begin
            got = (i < obs_words.size()) ? obs_words[i] : '1;
            n_assert++;
            if (got !== pattern(w, tag, i)) begin
                n_fail++;
                $display("FAIL init_word[%0d]: got %h required %h", i, got, pattern(w, tag, i));
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int w, tag;
        logic [DW-1:0] got;
        addr0 = $urandom;
        want = '{1, 0}; keep = '{0, 0};
        run_burst(1, 7, 0, 0, 0, 1, 1, -1, 0, 200);
        n_assert++;
        if (obs_push != 7 || pop0 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_pre: got push=%0d pop0=%b required 7/1", obs_push, pop0);
        end
        #2 rst_n = 0;
        #1;
        n_assert++;
        if ({pop0, pop1, done0, done1, npi_addr_req, npi_push, npi_addr, npi_wdata} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got pop=%b%b done=%b%b areq=%b push=%b addr=%h data=%h required all 0",
                     pop0, pop1, done0, done1, npi_addr_req, npi_push, npi_addr, npi_wdata);
        end
        @(posedge dram_clk);
        @(negedge dram_clk);
        rst_n = 1;
        @(posedge dram_clk); #1;
        model_last = 1;
        wi = '{0, 0};
        w   = rr_pick(1, 0, model_last);
        tag = bursts[w];
        run_burst(1, 0, 0, 0, 0, 1, 1, -1, 0, 200);
        model_last = w;
        n_assert++;
        if (obs_timeout || obs_push != BL || obs_done[w] != 1) begin
            n_fail++;
            $display("FAIL mid_reset_reserve: got timeout=%0d push=%0d done=%0d required 0/16/1",
                     obs_timeout, obs_push, obs_done[w]);
        end
        for (int i = 0; i < BL; i++) begin
            got = (i < obs_words.size()) ? obs_words[i] : '1;
            n_assert++;
            if (got !== pattern(w, tag, i)) begin
                n_fail++;
                $display("FAIL mid_reset_word[%0d]: got %h required %h", i, got, pattern(w, tag, i));
            end
        end
    endtask

    task automatic test_random();
        int mask, w, tag, dly, bad;
        logic [DW-1:0] got;
        for (int it = 0; it < 8; it++) begin
            mask  = $urandom_range(1, 3);
            addr0 = $urandom;
            addr1 = $urandom;
            dly   = $urandom_range(1, 5);
            want  = '{mask[0], mask[1]};
            keep  = '{0, 0};
            w   = rr_pick(mask[0], mask[1], model_last);
            tag = bursts[w];
            run_burst(1, 0, 1, 0, 0, dly, 1, -1, 0, 300);
            model_last = w;
            n_assert++;
            if (obs_timeout || obs_done_order.size() != 1 || obs_done_order[0] != w) begin
                n_fail++;
                $display("FAIL rand_grant[%0d]: got %0d required %0d", it,
                         (obs_done_order.size() > 0) ? obs_done_order[0] : -1, w);
            end
            n_assert++;
            if (obs_push != BL || obs_pop[w] != BL || obs_pop[1 - w] != 0 ||
                obs_af_push != 0 || obs_viol != 0) begin
                n_fail++;
                $display("FAIL rand_counts[%0d]: got push=%0d pop=%0d/%0d af_push=%0d viol=%0d required 16/16/0/0/0",
                         it, obs_push, obs_pop[w], obs_pop[1 - w], obs_af_push, obs_viol);
            end
            bad = 0;
            foreach (obs_addr[i]) if (obs_addr[i] !== aligned(w ? addr1 : addr0)) bad++;
            n_assert++;
            if (obs_addr.size() != dly || bad != 0) begin
                n_fail++;
                $display("FAIL rand_addr[%0d]: got %0d req cycles (%0d wrong) required %0d at %h",
                         it, obs_addr.size(), bad, dly, aligned(w ? addr1 : addr0));
            end
            for (int i = 0; i < BL; i++) begin
                got = (i < obs_words.size()) ? obs_words[i] : '1;
                n_assert++;
                if (got !== pattern(w, tag, i)) begin
                    n_fail++;
                    $display("FAIL rand_word[%0d][%0d]: got %h required %h", it, i, got,
                             pattern(w, tag, i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_almost_full();
        test_addr_ack_delay();
        test_init_done();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
